imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_loader_word_assembler.sv | 51 +++++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state encoding and the memory geometry.
// Geometry is fixed at 64 words of 4 bytes with 6-bit word addresses.
package imem_loader_pkg;
  localparam int DEPTH          = 64;
  localparam int ADDR_W         = 6;
  localparam int BYTES_PER_WORD = 4;
  localparam int MAX_WORDS      = 64;
  localparam int BCNT_W         = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_FILL,
    ST_DONE,
    ST_ERR
  } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Bundles the loader's byte stream, RAM write port and status lines.
// Pure wiring, so it adds no latency.
// Stream backpressure is carried by in_ready (valid/ready handshake).
interface imem_loader_if #(
  parameter int N = 32
);
  import imem_loader_pkg::*;

  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [N-1:0]      wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;

  // Loader side.
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, we, waddr, wdata, busy, done, error, cpu_hold
  );

  // Stream source / system side.
  modport master (
    output start, in_valid, in_data,
    input  in_ready, we, waddr, wdata, busy, done, error, cpu_hold
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs stream bytes little-endian into N-bit words.
// word_vld/word_dat are combinational on the cycle the last byte of a word is taken.
// Never stalls: it only advances on byte_vld, so input gaps keep partial bytes intact.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         byte_vld,
  input  logic [7:0]   byte_dat,
  output logic         word_vld,
  output logic [N-1:0] word_dat
);
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]      sh_q,  sh_d;

  // Shift each new byte in from the top so the first byte ends up in bits [7:0].
  always_comb begin
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    word_vld = 1'b0;
    if (clr) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (byte_vld) begin
      sh_d = {byte_dat, sh_q[N-1:8]};
      if (cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
        word_vld = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign word_dat = sh_d;

  // Byte counter and shift register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Loads a header+word byte stream into instruction RAM, zero-filling unused words.
// A word write appears one cycle after its last byte is accepted; fill writes come one per cycle.
// in_ready is high in HDR/DATA only and is never dropped for a write, so bytes flow without bubbles.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = imem_loader_pkg::DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  imem_loader_if.slave   bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        MAX_W     = 8'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [7:0]        wtot_q,  wtot_d;
  logic              last_q,  last_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [N-1:0]      wdata_q, wdata_d;

  logic         in_ready;
  logic         fire;
  logic         asm_clr;
  logic         word_vld;
  logic [N-1:0] word_dat;
  logic         last_word;

  assign fire      = bus.in_valid && in_ready;
  assign last_word = (8'(idx_q) + 8'd1) == wtot_q;

  word_assembler #(.N(N)) u_asm (
    .clk      (clk),
    .reset    (reset),
    .clr      (asm_clr),
    .byte_vld (fire && (state_q == ST_DATA)),
    .byte_dat (bus.in_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: FILL also covers the single trailing cycle after the last write is issued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_HDR;
      ST_HDR: begin
        if (fire) begin
          if (bus.in_data == 8'd0)       state_d = ST_FILL;
          else if (bus.in_data > MAX_W)  state_d = ST_ERR;
          else                           state_d = ST_DATA;
        end
      end
      ST_DATA: if (word_vld && last_word) state_d = ST_FILL;
      ST_FILL: if (last_q) state_d = ST_DONE;
      ST_DONE, ST_ERR: if (bus.start) state_d = ST_HDR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and write-port/counter next values; the address counter saturates at the last word.
  always_comb begin
    in_ready = (state_q == ST_HDR) || (state_q == ST_DATA);
    asm_clr  = 1'b0;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    wtot_d   = wtot_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          asm_clr = 1'b1;
          idx_d   = '0;
          wtot_d  = '0;
          last_d  = 1'b0;
        end
      end
      ST_HDR: begin
        if (fire) begin
          wtot_d = bus.in_data;
          idx_d  = '0;
          last_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (word_vld) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = word_dat;
          if (idx_q == LAST_ADDR) last_d = 1'b1;
          else                    idx_d  = idx_q + 1'b1;
        end
      end
      ST_FILL: begin
        if (!last_q) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = '0;
          if (idx_q == LAST_ADDR) last_d = 1'b1;
          else                    idx_d  = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered write port and session counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      wtot_q  <= '0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      idx_q   <= idx_d;
      wtot_q  <= wtot_d;
      last_q  <= last_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.busy     = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_FILL);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.error    = (state_q == ST_ERR);
  assign bus.cpu_hold = (state_q != ST_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a negedge monitor pops and compares.
// Directed sessions cover fill, full image, header reject, mid-session reset and stalled streams.
// Every wait is bounded; a stuck DUT shows up as a FAIL line before the summary.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.N(32)) bus ();

  imem_loader #(.N(32), .DEPTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_wr  = 0;
  int  cyc   = 0;
  int  wr_cyc [64];
  bit  prev63 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      prev63 = 1'b0;
    end else begin
      if (prev63) begin
        chk("done_after_63", 32'(bus.done), 32'd1);
        chk("hold_after_63", 32'(bus.cpu_hold), 32'd0);
        prev63 = 1'b0;
      end
      if (bus.we) begin
        wr_t e;
        n_wr++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_we: got write %0d:%h, required no write", bus.waddr, bus.wdata);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", 32'(bus.waddr), 32'(e.a));
          chk("wdata", bus.wdata, e.d);
        end
        wr_cyc[bus.waddr] = cyc;
        if (bus.waddr == 6'd63) prev63 = 1'b1;
      end
    end
  end

  task automatic push(input int a, input logic [31:0] d);
    wr_t e;
    e.a = 6'(a);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_fill(input int from);
    for (int a = from; a < 64; a++) push(a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL in_ready_timeout: got no in_ready in 100 cycles, required in_ready for byte %h", b);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int t = 0;
    while (!(bus.done || bus.error) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done/error in 400 cycles, required done or error", tag);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_we"},       32'(bus.we),       32'd0);
    chk({tag, "_waddr"},    32'(bus.waddr),    32'd0);
    chk({tag, "_wdata"},    bus.wdata,         32'd0);
    chk({tag, "_busy"},     32'(bus.busy),     32'd0);
    chk({tag, "_done"},     32'(bus.done),     32'd0);
    chk({tag, "_error"},    32'(bus.error),    32'd0);
    chk({tag, "_hold"},     32'(bus.cpu_hold), 32'd1);
  endtask

  logic [31:0] s5w [5] = '{32'h01234567, 32'h89abcdef, 32'h00ff00ff, 32'h13579bdf, 32'h2468ace0};
  logic [7:0]  s6b [9] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'hf8, 8'h02, 8'h80, 8'h00, 8'hf8};
  int          s6g [9] = '{0, 2, 1, 3, 0, 5, 1, 0, 2};

  initial begin
    int w0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    idle(3);
    chk_reset_state("rst");
    reset = 1'b1;
    idle(2);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Scenario 1: two words then zero fill.
    w0 = n_wr;
    push(0, 32'hf8000001);
    push(1, 32'hf8008002);
    push_fill(2);
    pulse_start();
    chk("s1_busy_hdr", 32'(bus.busy), 32'd1);
    send_byte(8'h02);
    send_word(32'hf8000001);
    send_word(32'hf8008002);
    wait_end("s1");
    chk("s1_done",  32'(bus.done),     32'd1);
    chk("s1_hold",  32'(bus.cpu_hold), 32'd0);
    chk("s1_busy",  32'(bus.busy),     32'd0);
    chk("s1_nwr",   32'(n_wr - w0),    32'd64);
    chk("s1_fill_gap1",  32'(wr_cyc[2] - wr_cyc[1]),  32'd1);
    chk("s1_fill_span",  32'(wr_cyc[63] - wr_cyc[2]), 32'd61);
    chk("s1_queue", 32'(exp_q.size()), 32'd0);
    idle(2);
    chk("s1_done_held", 32'(bus.done), 32'd1);

    // Scenario 2: empty image, restart from DONE.
    w0 = n_wr;
    push_fill(0);
    pulse_start();
    chk("s2_restart_done", 32'(bus.done),     32'd0);
    chk("s2_restart_hold", 32'(bus.cpu_hold), 32'd1);
    chk("s2_restart_busy", 32'(bus.busy),     32'd1);
    send_byte(8'h00);
    wait_end("s2");
    chk("s2_done",  32'(bus.done),  32'd1);
    chk("s2_nwr",   32'(n_wr - w0), 32'd64);
    chk("s2_queue", 32'(exp_q.size()), 32'd0);

    // Scenario 3: full 64-word image, back-to-back bytes 0..255.
    w0 = n_wr;
    for (int i = 0; i < 64; i++)
      push(i, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    pulse_start();
    send_byte(8'h40);
    for (int j = 0; j < 256; j++) send_byte(8'(j));
    wait_end("s3");
    chk("s3_done",  32'(bus.done),  32'd1);
    chk("s3_nwr",   32'(n_wr - w0), 32'd64);
    chk("s3_span",  32'(wr_cyc[63] - wr_cyc[0]), 32'd252);
    chk("s3_queue", 32'(exp_q.size()), 32'd0);

    // Scenario 4: header 65 rejected, then recovery.
    w0 = n_wr;
    pulse_start();
    send_byte(8'h41);
    idle(3);
    chk("s4_error",    32'(bus.error),    32'd1);
    chk("s4_hold",     32'(bus.cpu_hold), 32'd1);
    chk("s4_done",     32'(bus.done),     32'd0);
    chk("s4_busy",     32'(bus.busy),     32'd0);
    chk("s4_in_ready", 32'(bus.in_ready), 32'd0);
    chk("s4_nwr",      32'(n_wr - w0),    32'd0);
    push(0, 32'hdeadbeef);
    push_fill(1);
    pulse_start();
    chk("s4_restart_err",  32'(bus.error), 32'd0);
    chk("s4_restart_busy", 32'(bus.busy),  32'd1);
    send_byte(8'h01);
    send_word(32'hdeadbeef);
    wait_end("s4");
    chk("s4_rec_done",  32'(bus.done),  32'd1);
    chk("s4_rec_error", 32'(bus.error), 32'd0);
    chk("s4_queue", 32'(exp_q.size()), 32'd0);

    // Scenario 5: reset while word 2 is being written.
    for (int k = 0; k < 3; k++) push(k, s5w[k]);
    pulse_start();
    send_byte(8'h05);
    for (int k = 0; k < 3; k++) send_word(s5w[k]);
    #1 reset = 1'b0;
    #1 chk_reset_state("s5_rst");
    chk("s5_queue_at_rst", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    chk("s5_hold_after", 32'(bus.cpu_hold), 32'd1);
    chk("s5_done_after", 32'(bus.done),     32'd0);
    w0 = n_wr;
    for (int k = 0; k < 5; k++) push(k, s5w[k]);
    push_fill(5);
    pulse_start();
    send_byte(8'h05);
    for (int k = 0; k < 5; k++) send_word(s5w[k]);
    wait_end("s5");
    chk("s5_done",  32'(bus.done),  32'd1);
    chk("s5_nwr",   32'(n_wr - w0), 32'd64);
    chk("s5_queue", 32'(exp_q.size()), 32'd0);

    // Scenario 6: scenario 1 stream with in_valid gaps and stray start pulses in DATA.
    w0 = n_wr;
    push(0, 32'hf8000001);
    push(1, 32'hf8008002);
    push_fill(2);
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      if (s6g[k] > 0) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        idle(s6g[k] - 1);
      end
      send_byte(s6b[k]);
    end
    wait_end("s6");
    chk("s6_done",  32'(bus.done),  32'd1);
    chk("s6_nwr",   32'(n_wr - w0), 32'd64);
    chk("s6_queue", 32'(exp_q.size()), 32'd0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
